fpu_frm_ctrl: RTL and testbench

- Sequences the 3-bit FPU rounding-mode (frm) register, which is a plain enabled register external to this block.
- Tracks in-flight FPU operations and gates new FPU issue.
- Serialises CSR read/write/set/clear of frm, so frm only changes when no FPU op is in flight.
- Resolves each issuing instruction's rounding mode (static or dynamic) and flags illegal modes.
- Sits between the decode/issue stage, the CSR unit and the FPU pipeline.

---
 rtl/fpu_frm_ctrl.sv | 162 ++++++++++++++++
 tb/tb_fpu_frm_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_frm_ctrl.sv
// fpu_frm_ctrl
// Sequences the FPU rounding-mode (frm) register. It counts in-flight FPU
// operations, decides whether a new FPU op may issue, and serialises CSR
// read/write/set/clear accesses to frm. frm only changes when the FPU
// pipeline is empty. It also resolves each issuing op's rounding mode
// (static or dynamic) and flags reserved modes.
//
// Ports:
//   clk, clr      clock and synchronous active-high reset
//   issue_req     decode requests issue of an FPU op this cycle
//   inst_rm       rm field of the requesting instruction
//   issue_gnt     op accepted this cycle (combinational)
//   eff_rm        resolved rounding mode (combinational)
//   rm_illegal    resolved mode is reserved; the op must trap (combinational)
//   retire        FPU completed one op this cycle
//   inflight      current outstanding-op count
//   csr_req       CSR access to frm, held high until csr_done
//   csr_op        00 read, 01 write, 10 set bits, 11 clear bits
//   csr_wdata     CSR operand
//   csr_rdata     old frm value, valid while csr_done = 1
//   csr_done      one-cycle completion pulse
//   frm_q         current value of the external frm register
//   frm_d, frm_e  next value and write enable for the frm register
module fpu_frm_ctrl #(
  parameter int          MAX_INFLIGHT = 4,
  parameter logic [2:0]  DYN_RM       = 3'b111,
  localparam int         CW           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          issue_req,
  input  logic [2:0]    inst_rm,
  output logic          issue_gnt,
  output logic [2:0]    eff_rm,
  output logic          rm_illegal,
  input  logic          retire,
  output logic [CW-1:0] inflight,
  input  logic          csr_req,
  input  logic [1:0]    csr_op,
  input  logic [2:0]    csr_wdata,
  output logic [2:0]    csr_rdata,
  output logic          csr_done,
  input  logic [2:0]    frm_q,
  output logic [2:0]    frm_d,
  output logic          frm_e
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);
  localparam logic [CW-1:0] ONE     = CW'(1);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [1:0]    op_q, op_d;
  logic [2:0]    wdata_q, wdata_d;

  assign inflight = inflight_q;

  // Rounding-mode resolution. Modes 101/110/111 are reserved; this also
  // catches a reserved value sitting in frm when the op asks for dynamic rm.
  always_comb begin
    eff_rm     = (inst_rm == DYN_RM) ? frm_q : inst_rm;
    rm_illegal = eff_rm[2] & (eff_rm[1] | eff_rm[0]);
  end

  // Issue is only possible from IDLE and a pending CSR request takes
  // priority, so no new op can slip in once an frm access has started.
  always_comb begin
    issue_gnt = issue_req & (state_q == IDLE) & ~csr_req &
                (inflight_q < MAX_CNT) & ~rm_illegal;
  end

  // Outstanding-op counter. A simultaneous grant and retire cancel out;
  // a stray retire at zero is ignored rather than wrapping.
  always_comb begin
    inflight_d = inflight_q;
    if (issue_gnt && !retire) begin
      inflight_d = inflight_q + ONE;
    end else if (retire && !issue_gnt && (inflight_q != '0)) begin
      inflight_d = inflight_q - ONE;
    end
  end

  // CSR sequencing. Reads skip the drain because they do not change frm.
  // The op and operand are captured on entry; later values on csr_op and
  // csr_wdata while the request is held are ignored.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    wdata_d   = wdata_q;
    csr_done  = 1'b0;
    csr_rdata = 3'b000;
    frm_e     = 1'b0;
    frm_d     = 3'b000;
    unique case (state_q)
      IDLE: begin
        if (csr_req) begin
          op_d    = csr_op;
          wdata_d = csr_wdata;
          state_d = (csr_op == OP_READ) ? COMMIT : DRAIN;
        end
      end
      DRAIN: begin
        if (inflight_q == '0) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        csr_done  = 1'b1;
        csr_rdata = frm_q;
        unique case (op_q)
          OP_WRITE: begin
            frm_e = 1'b1;
            frm_d = wdata_q;
          end
          OP_SET: begin
            frm_e = 1'b1;
            frm_d = frm_q | wdata_q;
          end
          OP_CLEAR: begin
            frm_e = 1'b1;
            frm_d = frm_q & ~wdata_q;
          end
          default: begin
            frm_e = 1'b0;
            frm_d = 3'b000;
          end
        endcase
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers. Reset abandons any access in progress.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      inflight_q <= '0;
      op_q       <= 2'b00;
      wdata_q    <= 3'b000;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      op_q       <= op_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule

// File: tb/tb_fpu_frm_ctrl.sv
// Directed testbench for fpu_frm_ctrl. Models the external frm register
// (with a bench-side load port to preset its value) and walks through
// issue, counting, rounding-mode resolution and CSR access sequences.
module tb_fpu_frm_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       issue_req;
  logic [2:0] inst_rm;
  logic       issue_gnt;
  logic [2:0] eff_rm;
  logic       rm_illegal;
  logic       retire;
  logic [2:0] inflight;
  logic       csr_req;
  logic [1:0] csr_op;
  logic [2:0] csr_wdata;
  logic [2:0] csr_rdata;
  logic       csr_done;
  logic [2:0] frm_q = 3'b000;
  logic [2:0] frm_d;
  logic       frm_e;

  logic       frm_load = 1'b0;
  logic [2:0] frm_load_val = 3'b000;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_frm_ctrl dut (
    .clk        (clk),
    .clr        (clr),
    .issue_req  (issue_req),
    .inst_rm    (inst_rm),
    .issue_gnt  (issue_gnt),
    .eff_rm     (eff_rm),
    .rm_illegal (rm_illegal),
    .retire     (retire),
    .inflight   (inflight),
    .csr_req    (csr_req),
    .csr_op     (csr_op),
    .csr_wdata  (csr_wdata),
    .csr_rdata  (csr_rdata),
    .csr_done   (csr_done),
    .frm_q      (frm_q),
    .frm_d      (frm_d),
    .frm_e      (frm_e)
  );

  // External frm register owned outside the DUT
  always @(posedge clk) begin
    if (frm_load)   frm_q <= frm_load_val;
    else if (frm_e) frm_q <= frm_d;
  end

  // Drive one cycle of inputs at the falling edge, then let logic settle
  task automatic applyStimulus(input logic c, input logic ld, input logic [2:0] ldv,
                               input logic ireq, input logic [2:0] irm, input logic ret,
                               input logic creq, input logic [1:0] cop,
                               input logic [2:0] cwd);
    @(negedge clk);
    clr          = c;
    frm_load     = ld;
    frm_load_val = ldv;
    issue_req    = ireq;
    inst_rm      = irm;
    retire       = ret;
    csr_req      = creq;
    csr_op       = cop;
    csr_wdata    = cwd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    $display("[TB] start");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset state
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_inflight", 8'(inflight), 8'd0);
    checkOutput("rst_done", 8'(csr_done), 8'd0);
    checkOutput("rst_frm_e", 8'(frm_e), 8'd0);

    // three issues with static rm 000
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 3'b000, 0, 0, 0, 0);
      checkOutput("issue_gnt", 8'(issue_gnt), 8'd1);
      checkOutput("issue_cnt", 8'(inflight), 8'(i));
    end
    checkOutput("static_eff", 8'(eff_rm), 8'd0);
    checkOutput("static_ill", 8'(rm_illegal), 8'd0);

    // issue plus retire: count stays 3
    applyStimulus(0, 0, 0, 1, 3'b000, 1, 0, 0, 0);
    checkOutput("gnt_ret_gnt", 8'(issue_gnt), 8'd1);
    checkOutput("gnt_ret_pre", 8'(inflight), 8'd3);
    applyStimulus(0, 0, 0, 1, 3'b000, 0, 0, 0, 0);
    checkOutput("gnt_ret_cnt", 8'(inflight), 8'd3);
    checkOutput("gnt_to4", 8'(issue_gnt), 8'd1);

    // full at 4: grant blocked
    applyStimulus(0, 0, 0, 1, 3'b000, 0, 0, 0, 0);
    checkOutput("full_cnt", 8'(inflight), 8'd4);
    checkOutput("full_gnt", 8'(issue_gnt), 8'd0);

    // drain by retires, then extra retires at zero
    for (int i = 4; i > 0; i--) begin
      applyStimulus(0, 0, 0, 0, 3'b000, 1, 0, 0, 0);
      checkOutput("ret_cnt", 8'(inflight), 8'(i));
    end
    applyStimulus(0, 0, 0, 0, 3'b000, 1, 0, 0, 0);
    checkOutput("ret_zero", 8'(inflight), 8'd0);
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    checkOutput("no_underflow", 8'(inflight), 8'd0);

    // preset frm = 001, dynamic rm resolves to it
    applyStimulus(0, 1, 3'b001, 0, 3'b000, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 3'b111, 0, 0, 0, 0);
    checkOutput("dyn_eff", 8'(eff_rm), 8'd1);
    checkOutput("dyn_ill", 8'(rm_illegal), 8'd0);
    checkOutput("dyn_gnt", 8'(issue_gnt), 8'd1);
    applyStimulus(0, 0, 0, 1, 3'b101, 0, 0, 0, 0);
    checkOutput("rsv_eff", 8'(eff_rm), 8'd5);
    checkOutput("rsv_ill", 8'(rm_illegal), 8'd1);
    checkOutput("rsv_gnt", 8'(issue_gnt), 8'd0);
    applyStimulus(0, 0, 0, 1, 3'b000, 0, 0, 0, 0);
    checkOutput("gnt_two", 8'(issue_gnt), 8'd1);

    // CSR write 100 with 2 in flight; CSR beats issue in same cycle
    applyStimulus(0, 0, 0, 1, 3'b000, 0, 1, 2'b01, 3'b100);
    checkOutput("wr_cnt", 8'(inflight), 8'd2);
    checkOutput("csr_prio_gnt", 8'(issue_gnt), 8'd0);
    checkOutput("wr_idle_done", 8'(csr_done), 8'd0);
    // drain: changed csr_op/wdata must be ignored
    applyStimulus(0, 0, 0, 1, 3'b000, 1, 1, 2'b00, 3'b000);
    checkOutput("drain_gnt", 8'(issue_gnt), 8'd0);
    checkOutput("drain_done", 8'(csr_done), 8'd0);
    checkOutput("drain_frm_e", 8'(frm_e), 8'd0);
    applyStimulus(0, 0, 0, 1, 3'b000, 1, 1, 2'b00, 3'b000);
    checkOutput("drain_cnt1", 8'(inflight), 8'd1);
    checkOutput("drain_gnt2", 8'(issue_gnt), 8'd0);
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 1, 2'b00, 3'b000);
    checkOutput("drain_cnt0", 8'(inflight), 8'd0);
    checkOutput("drain_done0", 8'(csr_done), 8'd0);
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 1, 2'b00, 3'b000);
    checkOutput("wr_done", 8'(csr_done), 8'd1);
    checkOutput("wr_frm_e", 8'(frm_e), 8'd1);
    checkOutput("wr_frm_d", 8'(frm_d), 8'd4);
    checkOutput("wr_rdata", 8'(csr_rdata), 8'd1);
    applyStimulus(0, 0, 0, 0, 3'b111, 0, 0, 0, 0);
    checkOutput("wr_after_done", 8'(csr_done), 8'd0);
    checkOutput("wr_after_frm_e", 8'(frm_e), 8'd0);
    checkOutput("wr_after_frm_d", 8'(frm_d), 8'd0);
    checkOutput("wr_new_eff", 8'(eff_rm), 8'd4);

    // set 100 on frm 011 -> 111, then reserved frm traps dynamic ops
    applyStimulus(0, 1, 3'b011, 0, 3'b000, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 1, 2'b10, 3'b100);
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 1, 2'b10, 3'b100);
    checkOutput("set_drain_done", 8'(csr_done), 8'd0);
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 1, 2'b10, 3'b100);
    checkOutput("set_done", 8'(csr_done), 8'd1);
    checkOutput("set_frm_e", 8'(frm_e), 8'd1);
    checkOutput("set_frm_d", 8'(frm_d), 8'd7);
    checkOutput("set_rdata", 8'(csr_rdata), 8'd3);
    applyStimulus(0, 0, 0, 1, 3'b111, 0, 0, 0, 0);
    checkOutput("rsv_frm_eff", 8'(eff_rm), 8'd7);
    checkOutput("rsv_frm_ill", 8'(rm_illegal), 8'd1);
    checkOutput("rsv_frm_gnt", 8'(issue_gnt), 8'd0);

    // clear 010 on frm 011 -> 001
    applyStimulus(0, 1, 3'b011, 0, 3'b000, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 1, 2'b11, 3'b010);
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 1, 2'b11, 3'b010);
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 1, 2'b11, 3'b010);
    checkOutput("clr_done", 8'(csr_done), 8'd1);
    checkOutput("clr_frm_d", 8'(frm_d), 8'd1);
    checkOutput("clr_rdata", 8'(csr_rdata), 8'd3);
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 0, 0, 0);

    // read: completes one cycle after request, no frm write
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 1, 2'b00, 3'b101);
    checkOutput("rd_req_done", 8'(csr_done), 8'd0);
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 1, 2'b00, 3'b101);
    checkOutput("rd_done", 8'(csr_done), 8'd1);
    checkOutput("rd_frm_e", 8'(frm_e), 8'd0);
    checkOutput("rd_frm_d", 8'(frm_d), 8'd0);
    checkOutput("rd_rdata", 8'(csr_rdata), 8'd1);
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    checkOutput("rd_after_done", 8'(csr_done), 8'd0);

    // reset while draining abandons the write
    applyStimulus(0, 0, 0, 1, 3'b000, 0, 0, 0, 0);
    checkOutput("pre_rst_gnt", 8'(issue_gnt), 8'd1);
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 1, 2'b01, 3'b010);
    checkOutput("pre_rst_cnt", 8'(inflight), 8'd1);
    applyStimulus(1, 0, 0, 0, 3'b000, 0, 1, 2'b01, 3'b010);
    checkOutput("drain_rst_done", 8'(csr_done), 8'd0);
    applyStimulus(0, 0, 0, 1, 3'b000, 0, 0, 0, 0);
    checkOutput("post_rst_cnt", 8'(inflight), 8'd0);
    checkOutput("post_rst_done", 8'(csr_done), 8'd0);
    checkOutput("post_rst_frm_e", 8'(frm_e), 8'd0);
    checkOutput("post_rst_gnt", 8'(issue_gnt), 8'd1);
    applyStimulus(0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    checkOutput("post_rst_done2", 8'(csr_done), 8'd0);
    checkOutput("post_rst_frm_e2", 8'(frm_e), 8'd0);
    checkOutput("post_rst_cnt2", 8'(inflight), 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
